nco_sweep_ctrl: RTL and testbench

- Sequencer for the 30-bit-phase-increment NCO in the DQPSK modem.
- Accepts a sweep configuration: start/stop increment, step and dwell. Drives the NCO phase increment and clock enable.
- Performs single linear up-sweeps or continuous triangle sweeps, in sample-synchronous steps.
- Gates the NCO until its output pipeline is primed.
- Used for carrier acquisition, calibration chirps and lab frequency sweeps.

---
 rtl/nco_ctrl_pkg.sv | 24 ++
 rtl/nco_step_alu.sv | 30 +++
 rtl/nco_sweep_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_ctrl_pkg.sv
// Shared types for the NCO sweep controller: state encoding and the
// captured sweep configuration.
package nco_ctrl_pkg;

    localparam int unsigned PHI_W_DFLT   = 30;
    localparam int unsigned DWELL_W_DFLT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_UP    = 2'd2,
        ST_DOWN  = 2'd3
    } state_e;

    // dwell is stored already clamped to at least 1
    typedef struct packed {
        logic [PHI_W_DFLT-1:0]   f_start;
        logic [PHI_W_DFLT-1:0]   f_stop;
        logic [PHI_W_DFLT-1:0]   f_step;
        logic [DWELL_W_DFLT-1:0] dwell;
        logic                    tri_mode;
    } sweep_cfg_t;

endpackage

// File: rtl/nco_step_alu.sv
// One sweep step: widened add (up) or subtract (down) of the step size,
// clamped to the leg bound, with a flag when the clamp was hit.
module nco_step_alu #(
    parameter int unsigned PHI_W = 30
) (
    input  logic [PHI_W-1:0] i_cur,
    input  logic [PHI_W-1:0] i_step,
    input  logic [PHI_W-1:0] i_bound,
    input  logic             i_down,
    output logic [PHI_W-1:0] o_next,
    output logic             o_leg_end
);

    logic [PHI_W:0] w_sum;

    always_comb begin
        w_sum     = '0;
        o_leg_end = 1'b0;
        if (i_down) begin
            // MSB of the widened difference is the borrow
            w_sum     = {1'b0, i_cur} - {1'b0, i_step};
            o_leg_end = w_sum[PHI_W] || (w_sum[PHI_W-1:0] <= i_bound);
        end else begin
            w_sum     = {1'b0, i_cur} + {1'b0, i_step};
            o_leg_end = (w_sum >= {1'b0, i_bound});
        end
        o_next = o_leg_end ? i_bound : w_sum[PHI_W-1:0];
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// NCO sweep sequencer: primes the NCO, then steps its phase increment
// linearly up (single) or up/down (triangle) once per dwell of valid samples.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int unsigned PHI_W     = PHI_W_DFLT,
    parameter int unsigned DWELL_W   = DWELL_W_DFLT,
    parameter int unsigned PRIME_MAX = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHI_W-1:0]   cfg_f_start,
    input  logic [PHI_W-1:0]   cfg_f_stop,
    input  logic [PHI_W-1:0]   cfg_f_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_tri,
    input  logic               abort,
    input  logic               nco_out_valid,
    output logic [PHI_W-1:0]   phi_inc_o,
    output logic               nco_clken,
    output logic               sweep_active,
    output logic               step_strobe,
    output logic               done,
    output logic               cfg_err
);

    localparam int unsigned PRIME_W = $clog2(PRIME_MAX + 1);

    state_e             r_state, w_state_nxt;
    sweep_cfg_t         r_cfg, w_cfg_nxt;
    logic [PHI_W-1:0]   r_phi, w_phi_nxt;
    logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_nxt;
    logic [PRIME_W-1:0] r_prime_cnt, w_prime_nxt;
    logic               r_clken, w_clken_nxt;
    logic               r_strobe, w_strobe_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;
    logic               r_at_bound, w_at_bound_nxt;
    logic               r_ready, r_active;

    logic               w_cfg_ok, w_sample_end, w_prime_to, w_single_end;
    logic               w_step_down, w_alu_leg_end;
    logic [PHI_W-1:0]   w_bound, w_alu_next;
    logic [DWELL_W-1:0] w_dwell_eff;

    assign w_cfg_ok     = (cfg_f_stop >= cfg_f_start) && (cfg_f_step != '0);
    assign w_dwell_eff  = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
    assign w_sample_end = nco_out_valid && (r_dwell_cnt == DWELL_W'(1));
    assign w_prime_to   = (r_prime_cnt == PRIME_W'(PRIME_MAX - 1));
    assign w_single_end = (r_state == ST_UP) && r_at_bound && !r_cfg.tri_mode;

    // Sitting on the current leg's bound means the next step turns around.
    assign w_step_down  = (r_state == ST_DOWN) ^ r_at_bound;
    assign w_bound      = w_step_down ? r_cfg.f_start : r_cfg.f_stop;

    nco_step_alu #(.PHI_W(PHI_W)) u_alu (
        .i_cur     (r_phi),
        .i_step    (r_cfg.f_step),
        .i_bound   (w_bound),
        .i_down    (w_step_down),
        .o_next    (w_alu_next),
        .o_leg_end (w_alu_leg_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (cfg_valid && w_cfg_ok) w_state_nxt = ST_PRIME;
                ST_PRIME: begin
                    if (nco_out_valid)   w_state_nxt = ST_UP;
                    else if (w_prime_to) w_state_nxt = ST_IDLE;
                end
                ST_UP: begin
                    if (w_sample_end && r_at_bound)
                        w_state_nxt = r_cfg.tri_mode ? ST_DOWN : ST_IDLE;
                end
                default: if (w_sample_end && r_at_bound) w_state_nxt = ST_UP;
            endcase
        end
    end

    // Next values of every registered output and counter.
    always_comb begin
        w_cfg_nxt      = r_cfg;
        w_phi_nxt      = r_phi;
        w_clken_nxt    = r_clken;
        w_strobe_nxt   = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_dwell_nxt    = r_dwell_cnt;
        w_prime_nxt    = r_prime_cnt;
        w_at_bound_nxt = r_at_bound;
        if (abort) begin
            w_phi_nxt      = '0;
            w_clken_nxt    = 1'b0;
            w_dwell_nxt    = '0;
            w_prime_nxt    = '0;
            w_at_bound_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid && w_cfg_ok) begin
                        w_cfg_nxt   = '{f_start: cfg_f_start, f_stop: cfg_f_stop,
                                        f_step: cfg_f_step, dwell: w_dwell_eff,
                                        tri_mode: cfg_tri};
                        w_phi_nxt   = cfg_f_start;
                        w_clken_nxt = 1'b1;
                        w_prime_nxt = '0;
                    end else if (cfg_valid) begin
                        w_err_nxt = 1'b1;
                    end
                end
                ST_PRIME: begin
                    if (nco_out_valid) begin
                        w_dwell_nxt    = r_cfg.dwell;
                        w_at_bound_nxt = (r_cfg.f_start == r_cfg.f_stop);
                        w_prime_nxt    = '0;
                    end else if (w_prime_to) begin
                        w_err_nxt   = 1'b1;
                        w_clken_nxt = 1'b0;
                        w_prime_nxt = '0;
                    end else begin
                        w_prime_nxt = r_prime_cnt + PRIME_W'(1);
                    end
                end
                default: begin
                    if (nco_out_valid && !w_sample_end) begin
                        w_dwell_nxt = r_dwell_cnt - DWELL_W'(1);
                    end else if (w_sample_end && w_single_end) begin
                        w_done_nxt  = 1'b1;
                        w_clken_nxt = 1'b0;
                        w_dwell_nxt = '0;
                    end else if (w_sample_end) begin
                        w_phi_nxt      = w_alu_next;
                        w_strobe_nxt   = (w_alu_next != r_phi);
                        w_at_bound_nxt = w_alu_leg_end;
                        w_dwell_nxt    = r_cfg.dwell;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg       <= '0;
            r_phi       <= '0;
            r_clken     <= 1'b0;
            r_strobe    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_dwell_cnt <= '0;
            r_prime_cnt <= '0;
            r_at_bound  <= 1'b0;
            r_ready     <= 1'b1;
            r_active    <= 1'b0;
        end else begin
            r_cfg       <= w_cfg_nxt;
            r_phi       <= w_phi_nxt;
            r_clken     <= w_clken_nxt;
            r_strobe    <= w_strobe_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_prime_cnt <= w_prime_nxt;
            r_at_bound  <= w_at_bound_nxt;
            r_ready     <= (w_state_nxt == ST_IDLE);
            r_active    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign cfg_ready    = r_ready;
    assign sweep_active = r_active;
    assign phi_inc_o    = r_phi;
    assign nco_clken    = r_clken;
    assign step_strobe  = r_strobe;
    assign done         = r_done;
    assign cfg_err      = r_err;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed and random sweeps checked against an
// arithmetic model of the expected increment sequence.
module tb_nco_sweep_ctrl;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [29:0] cfg_f_start;
    logic [29:0] cfg_f_stop;
    logic [29:0] cfg_f_step;
    logic [15:0] cfg_dwell;
    logic        cfg_tri;
    logic        abort;
    logic        nco_out_valid;
    logic [29:0] phi_inc_o;
    logic        nco_clken;
    logic        sweep_active;
    logic        step_strobe;
    logic        done;
    logic        cfg_err;

    int total = 0;
    int bad   = 0;

    nco_sweep_ctrl #(.PHI_W(30), .DWELL_W(16), .PRIME_MAX(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_f_start   (cfg_f_start),
        .cfg_f_stop    (cfg_f_stop),
        .cfg_f_step    (cfg_f_step),
        .cfg_dwell     (cfg_dwell),
        .cfg_tri       (cfg_tri),
        .abort         (abort),
        .nco_out_valid (nco_out_valid),
        .phi_inc_o     (phi_inc_o),
        .nco_clken     (nco_clken),
        .sweep_active  (sweep_active),
        .step_strobe   (step_strobe),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_ready"},  64'(cfg_ready),    64'd1);
        chk({tag, "_active"}, 64'(sweep_active), 64'd0);
        chk({tag, "_phi"},    64'(phi_inc_o),    64'd0);
        chk({tag, "_clken"},  64'(nco_clken),    64'd0);
        chk({tag, "_strobe"}, 64'(step_strobe),  64'd0);
        chk({tag, "_done"},   64'(done),         64'd0);
        chk({tag, "_err"},    64'(cfg_err),      64'd0);
    endtask

    // kill: 0 none, 1 abort, 2 reset -- applied after kill_at dwell samples
    task automatic run_sweep(input logic [29:0] st, input logic [29:0] sp,
                             input logic [29:0] stp, input logic [15:0] dw,
                             input logic tr, input int pdel, input int mode,
                             input int kill, input int kill_at);
        longint seq[$];
        longint ls, lp, lt, v;
        int     d, need, s, total_s;
        bit     primed, exp_str, exp_str_n, ending, fin, up, tog;
        logic   vv;
        ls = st; lp = sp; lt = stp;
        d  = (dw == 16'd0) ? 1 : int'(dw);
        seq.delete();
        v = ls;
        seq.push_back(v);
        if (!tr) begin
            while (v < lp) begin
                v = (v + lt > lp) ? lp : v + lt;
                seq.push_back(v);
            end
            total_s = seq.size() * d;
        end else begin
            need = kill_at / d + 2;
            up   = 1'b1;
            while (seq.size() < need) begin
                if (up && v == lp) up = 1'b0;
                else if (!up && v == ls) up = 1'b1;
                v = up ? ((v + lt > lp) ? lp : v + lt) : ((v - lt < ls) ? ls : v - lt);
                seq.push_back(v);
            end
            total_s = 32'h7FFF_FFFF;
        end

        cfg_f_start = st; cfg_f_stop = sp; cfg_f_step = stp;
        cfg_dwell = dw; cfg_tri = tr; cfg_valid = 1'b1; nco_out_valid = 1'b0;
        step();
        chk("acc_active", 64'(sweep_active), 64'd1);
        chk("acc_ready",  64'(cfg_ready),    64'd0);
        chk("acc_phi",    64'(phi_inc_o),    64'(st));
        chk("acc_clken",  64'(nco_clken),    64'd1);
        cfg_valid   = 1'b0;
        cfg_f_start = 30'($urandom); cfg_f_stop = 30'($urandom);
        cfg_f_step  = 30'($urandom); cfg_dwell  = 16'($urandom);
        cfg_tri     = 1'($urandom);

        s = 0; primed = 1'b0; exp_str = 1'b0; ending = 1'b0; fin = 1'b0; tog = 1'b1;
        for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
            chk("strobe", 64'(step_strobe), 64'(exp_str));
            if (ending) begin
                chk("end_done",   64'(done),         64'd1);
                chk("end_active", 64'(sweep_active), 64'd0);
                chk("end_clken",  64'(nco_clken),    64'd0);
                chk("end_phi",    64'(phi_inc_o),    64'(sp));
                chk("end_ready",  64'(cfg_ready),    64'd1);
                step();
                chk("done_pulse", 64'(done), 64'd0);
                fin = 1'b1;
            end else begin
                chk("run_done",   64'(done),         64'd0);
                chk("run_active", 64'(sweep_active), 64'd1);
                if (kill != 0 && primed && s == kill_at) begin
                    if (kill == 1) abort = 1'b1;
                    else           reset = 1'b1;
                    nco_out_valid = 1'($urandom);
                    step();
                    abort = 1'b0; reset = 1'b0;
                    chk_idle_reset((kill == 1) ? "abort" : "midreset");
                    fin = 1'b1;
                end else begin
                    if (!primed) begin
                        vv = (pdel > 0) ? 1'b0 : 1'b1;
                        pdel--;
                    end else if (mode == 0) begin
                        vv = 1'b1;
                    end else if (mode == 1) begin
                        vv = tog;
                        tog = !tog;
                    end else begin
                        vv = 1'($urandom);
                    end
                    exp_str_n = 1'b0;
                    if (primed && vv) begin
                        chk("sample", 64'(phi_inc_o), 64'(seq[s / d]));
                        s++;
                        if (s % d == 0 && s < total_s && seq[s / d] != seq[s / d - 1])
                            exp_str_n = 1'b1;
                        if (!tr && s == total_s) ending = 1'b1;
                    end
                    if (!primed && vv) primed = 1'b1;
                    nco_out_valid = vv;
                    step();
                    exp_str = exp_str_n;
                end
            end
        end
        chk("sweep_finished", 64'(fin), 64'd1);
        nco_out_valid = 1'b0;
        step();
    endtask

    task automatic offer_bad(input string tag, input logic [29:0] st,
                             input logic [29:0] sp, input logic [29:0] stp);
        cfg_f_start = st; cfg_f_stop = sp; cfg_f_step = stp;
        cfg_dwell = 16'd2; cfg_tri = 1'b0; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk({tag, "_err"},    64'(cfg_err),      64'd1);
        chk({tag, "_active"}, 64'(sweep_active), 64'd0);
        chk({tag, "_ready"},  64'(cfg_ready),    64'd1);
        step();
        chk({tag, "_err_pulse"}, 64'(cfg_err),      64'd0);
        chk({tag, "_stay"},      64'(sweep_active), 64'd0);
    endtask

    initial begin
        logic [29:0] rs, rsp, rst;
        int          n;
        logic        rt;
        reset = 1'b1; cfg_valid = 1'b0; abort = 1'b0; nco_out_valid = 1'b0;
        cfg_f_start = '0; cfg_f_stop = '0; cfg_f_step = '0; cfg_dwell = '0; cfg_tri = 1'b0;
        step(); step();
        chk_idle_reset("reset");
        reset = 1'b0;
        step();

        // directed sweeps
        run_sweep(30'h1000_0000, 30'h1000_0030, 30'h10, 16'd4, 1'b0, 8, 0, 0, 0);
        run_sweep(30'd0, 30'd25, 30'd10, 16'd1, 1'b0, 2, 2, 0, 0);
        run_sweep(30'h3FFF_FFF0, 30'h3FFF_FFFF, 30'h20, 16'd2, 1'b0, 0, 2, 0, 0);
        run_sweep(30'd5, 30'd40, 30'd15, 16'd0, 1'b0, 3, 0, 0, 0);
        run_sweep(30'd500, 30'd500, 30'd7, 16'd3, 1'b0, 1, 2, 0, 0);
        run_sweep(30'd100, 30'd130, 30'd10, 16'd2, 1'b1, 4, 0, 1, 11);
        run_sweep(30'd500, 30'd500, 30'd7, 16'd2, 1'b1, 0, 2, 1, 7);
        run_sweep(30'd0, 30'd30, 30'd10, 16'd3, 1'b0, 5, 1, 0, 0);
        run_sweep(30'd0, 30'd100, 30'd10, 16'd2, 1'b0, 2, 0, 2, 5);

        // rejected configurations
        offer_bad("stop_lt_start", 30'd200, 30'd100, 30'd5);
        offer_bad("step_zero",     30'd100, 30'd200, 30'd0);

        // abort wins over a valid offer in IDLE
        cfg_f_start = 30'd10; cfg_f_stop = 30'd20; cfg_f_step = 30'd1;
        cfg_dwell = 16'd1; cfg_tri = 1'b0; cfg_valid = 1'b1; abort = 1'b1;
        step();
        abort = 1'b0; cfg_valid = 1'b0;
        chk_idle_reset("idle_abort");
        step();
        chk("idle_abort_later", 64'(sweep_active), 64'd0);

        // prime timeout
        cfg_f_start = 30'd50; cfg_f_stop = 30'd60; cfg_f_step = 30'd5;
        cfg_dwell = 16'd1; cfg_tri = 1'b0; cfg_valid = 1'b1; nco_out_valid = 1'b0;
        step();
        cfg_valid = 1'b0;
        n = 0;
        while (sweep_active === 1'b1 && n < 200) begin
            n++;
            step();
        end
        chk("prime_cycles", 64'(n),         64'd64);
        chk("prime_err",    64'(cfg_err),   64'd1);
        chk("prime_clken",  64'(nco_clken), 64'd0);
        chk("prime_ready",  64'(cfg_ready), 64'd1);
        step();
        chk("prime_err_pulse", 64'(cfg_err), 64'd0);

        // random sweeps
        for (int k = 0; k < 6; k++) begin
            rs  = 30'($urandom_range(0, 32'h3FFF_F000));
            rsp = rs + 30'($urandom_range(0, 300));
            rst = 30'($urandom_range(1, 80));
            rt  = 1'($urandom);
            run_sweep(rs, rsp, rst, 16'($urandom_range(0, 3)), rt,
                      int'($urandom_range(0, 10)), 2, rt ? 1 : 0,
                      int'($urandom_range(1, 40)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
